// File: rtl/itof_pkg.sv
// Shared constants for the integer/float conversion blocks: rounding-mode
// encodings and IEEE-754 single-precision field geometry.
package itof_pkg;

  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

endpackage

// File: rtl/lzc.sv
// Parametrised leading-zero counter built as a binary combine tree.
// count = W when the input is all zeros.
module lzc #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          all_zero
);

  localparam int L = $clog2(W);
  localparam int P = 1 << L;

  logic [P-1:0] padded;
  logic [L-1:0] cnt [0:L][0:P-1];
  logic         zf  [0:L][0:P-1];

  // Padding with ones below the operand keeps non-zero counts exact for any W.
  always_comb begin
    padded = '1;
    padded[P-1 -: W] = data;
    for (int k = 0; k <= L; k++) begin
      for (int i = 0; i < P; i++) begin
        cnt[k][i] = '0;
        zf[k][i]  = 1'b0;
      end
    end
    for (int i = 0; i < P; i++) begin
      zf[0][i] = ~padded[i];
    end
    for (int k = 1; k <= L; k++) begin
      for (int i = 0; i < (P >> k); i++) begin
        zf[k][i]  = zf[k-1][2*i] & zf[k-1][2*i+1];
        cnt[k][i] = zf[k-1][2*i+1] ? (cnt[k-1][2*i] | (L'(1) << (k - 1)))
                                   : cnt[k-1][2*i+1];
      end
    end
    all_zero = (data == '0);
    count    = all_zero ? CW'(W) : CW'(cnt[L][0]);
  end

endmodule

// File: rtl/itof_pipe.sv
// Pipelined integer-to-FP32 converter: operand register, then sign/abs,
// normalise and round/pack stages, all advancing together under a global stall.
module itof_pipe
  import itof_pkg::*;
#(
  parameter int IN_W = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_unsigned,
  input  logic            in_rm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic            out_inexact
);

  localparam int ZW = $clog2(IN_W + 1);
  localparam int XW = IN_W - 1 + FRAC_W + 2;

  // Handshake: a word moves on a rising edge where valid and ready are both
  // high; valid never depends on ready, and in_ready is high exactly when the
  // whole pipe advances (output slot empty or being consumed).
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic            v0, v1, v2;
  logic [IN_W-1:0] d0;
  logic            uns0, rm0;
  logic            sign1, rm1;
  logic [IN_W-1:0] mag1;
  logic            sign2, zero2, rm2;
  logic [EXP_W-1:0] exp2;
  logic [IN_W-1:0] norm2;

  logic            sign_c;
  logic [IN_W-1:0] mag_c;
  assign sign_c = !uns0 && d0[IN_W-1];
  assign mag_c  = sign_c ? -d0 : d0;

  logic [ZW-1:0]    lz;
  logic             zero_c;
  logic [IN_W-1:0]  norm_c;
  logic [EXP_W-1:0] exp_c;

  lzc #(.W(IN_W), .CW(ZW)) u_lzc (
    .data     (mag1),
    .count    (lz),
    .all_zero (zero_c)
  );

  assign norm_c = mag1 << lz;
  assign exp_c  = EXP_W'(IN_W - 1) - EXP_W'(lz);

  logic [XW-1:0]     ext;
  logic [FRAC_W-1:0] frac;
  logic              g, s, up;
  logic [FRAC_W+1:0] mant;
  logic [EXP_W-1:0]  exp_b;
  logic [31:0]       packed_c;
  logic              inexact_c;

  always_comb begin
    ext       = {norm2[IN_W-2:0], {(FRAC_W + 2){1'b0}}};
    frac      = ext[XW-1 -: FRAC_W];
    g         = ext[XW-1-FRAC_W];
    s         = |ext[XW-2-FRAC_W:0];
    up        = (rm2 == RM_RNE) && g && (s || frac[0]);
    mant      = {1'b0, norm2[IN_W-1], frac} + (FRAC_W + 2)'(up);
    // Top two mantissa bits are 01, or 10 after a rounding carry: adding them
    // to BIAS-1 gives the biased exponent including the carry bump.
    exp_b     = exp2 + EXP_W'(BIAS - 1) + EXP_W'(mant[FRAC_W+1:FRAC_W]);
    inexact_c = !zero2 && (g || s);
    packed_c  = zero2 ? '0 : {sign2, exp_b, mant[FRAC_W-1:0]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v0          <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else if (advance) begin
      v0        <= in_valid;
      v1        <= v0;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        out_data    <= packed_c;
        out_inexact <= inexact_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      d0    <= in_data;
      uns0  <= in_unsigned;
      rm0   <= in_rm;
      sign1 <= sign_c;
      mag1  <= mag_c;
      rm1   <= rm0;
      sign2 <= sign1;
      zero2 <= zero_c;
      exp2  <= exp_c;
      norm2 <= norm_c;
      rm2   <= rm1;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Directed bench for itof_pipe: hand-computed vector table, backpressure
// stream, mid-stream reset and an 8/16/64-bit width sweep against a model.
module tb_itof_pipe;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_unsigned, in_rm;
  logic        out_valid, out_ready, out_inexact;
  logic [31:0] in_data, out_data;

  logic        sw_valid, sw_unsigned, sw_rm;
  logic [63:0] sw_data;
  logic        rdy8, rdy16, rdy64;
  logic        ov8, ov16, ov64, ox8, ox16, ox64;
  logic [31:0] od8, od16, od64;
  logic [31:0] last8, last64;

  itof_pipe #(.IN_W(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_unsigned(in_unsigned), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inexact(out_inexact)
  );

  itof_pipe #(.IN_W(8)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(sw_valid), .in_ready(rdy8),
    .in_data(sw_data[7:0]), .in_unsigned(sw_unsigned), .in_rm(sw_rm),
    .out_valid(ov8), .out_ready(1'b1), .out_data(od8), .out_inexact(ox8)
  );

  itof_pipe #(.IN_W(16)) dut16 (
    .clk(clk), .rstn(rstn), .in_valid(sw_valid), .in_ready(rdy16),
    .in_data(sw_data[15:0]), .in_unsigned(sw_unsigned), .in_rm(sw_rm),
    .out_valid(ov16), .out_ready(1'b1), .out_data(od16), .out_inexact(ox16)
  );

  itof_pipe #(.IN_W(64)) dut64 (
    .clk(clk), .rstn(rstn), .in_valid(sw_valid), .in_ready(rdy64),
    .in_data(sw_data), .in_unsigned(sw_unsigned), .in_rm(sw_rm),
    .out_valid(ov64), .out_ready(1'b1), .out_data(od64), .out_inexact(ox64)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [31:0] data;
    logic        uns;
    logic        rm;
    logic [31:0] exp_data;
    logic        exp_inx;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Reference: {inexact, fp32} built by explicit shift/remainder arithmetic.
  function automatic logic [32:0] model(input logic [63:0] v, input int w,
                                        input logic uns, input logic rm);
    logic [63:0] mask, vm, mag, keep, rem, half;
    logic        sgn, inx;
    int          msb, sh;
    logic [7:0]  ex;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    vm   = v & mask;
    sgn  = !uns && vm[w-1];
    mag  = sgn ? ((~vm + 64'd1) & mask) : vm;
    if (mag == 64'd0) return 33'd0;
    msb = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) msb = i;
    inx = 1'b0;
    if (msb <= 23) begin
      keep = mag << (23 - msb);
    end else begin
      sh   = msb - 23;
      keep = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      if (!rm && (rem > half || (rem == half && keep[0]))) keep = keep + 64'd1;
      if (keep[24]) begin
        keep = keep >> 1;
        msb++;
      end
    end
    ex = 8'(msb + 127);
    return {inx, sgn, ex, keep[22:0]};
  endfunction

  task automatic run_vec(input logic [31:0] d, input logic uns, input logic rm,
                         input logic [31:0] ed, input logic ei, input string name);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_unsigned = uns; in_rm = rm; out_ready = 1'b1;
    #1 check({name, " in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, 3);
    check({name, " data"}, out_data, ed);
    check({name, " inexact"}, out_inexact, ei);
  endtask

  task automatic sweep(input logic [63:0] v, input logic uns, input logic rm);
    @(negedge clk);
    sw_valid = 1'b1; sw_data = v; sw_unsigned = uns; sw_rm = rm;
    @(negedge clk);
    sw_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("w8", {ov8, ox8, od8}, {1'b1, model(v, 8, uns, rm)});
    check("w16", {ov16, ox16, od16}, {1'b1, model(v, 16, uns, rm)});
    check("w64", {ov64, ox64, od64}, {1'b1, model(v, 64, uns, rm)});
    last8  = od8;
    last64 = od64;
  endtask

  initial begin
    logic [31:0] ops_d[10];
    logic        ops_u[10], ops_r[10];
    logic [32:0] e, prev_word;
    logic        prev_stall;
    int          sent, got;

    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_unsigned = 1'b0; in_rm = 1'b0;
    out_ready = 1'b1; sw_valid = 1'b0; sw_data = '0; sw_unsigned = 1'b0; sw_rm = 1'b0;

    vecs[0]  = '{32'h00000001, 1'b0, 1'b0, 32'h3F800000, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 1'b0, 1'b0, 32'hBF800000, 1'b0};
    vecs[2]  = '{32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0};
    vecs[3]  = '{32'h01000001, 1'b0, 1'b0, 32'h4B800000, 1'b1};
    vecs[4]  = '{32'h01000003, 1'b0, 1'b0, 32'h4B800002, 1'b1};
    vecs[5]  = '{32'h7FFFFFFF, 1'b0, 1'b0, 32'h4F000000, 1'b1};
    vecs[6]  = '{32'h7FFFFFFF, 1'b0, 1'b1, 32'h4EFFFFFF, 1'b1};
    vecs[7]  = '{32'h80000000, 1'b0, 1'b0, 32'hCF000000, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 1'b1, 1'b0, 32'h4F800000, 1'b1};
    vecs[9]  = '{32'hFFFFFFFF, 1'b1, 1'b1, 32'h4F7FFFFF, 1'b1};
    vecs[10] = '{32'h01000003, 1'b0, 1'b1, 32'h4B800001, 1'b1};
    vecs[11] = '{32'h00ABCDEF, 1'b0, 1'b0, 32'h4B2BCDEF, 1'b0};
    vecs[12] = '{32'hFFFFFFFE, 1'b0, 1'b1, 32'hC0000000, 1'b0};
    vecs[13] = '{32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b0};
    vecs[14] = '{32'h80000000, 1'b1, 1'b0, 32'h4F000000, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_inexact", out_inexact, 0);
    check("reset in_ready", in_ready, 1);
    check("reset w8 out", {ov8, od8}, 0);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i].data, vecs[i].uns, vecs[i].rm, vecs[i].exp_data,
              vecs[i].exp_inx, $sformatf("vec%0d", i));
    end

    // backpressure stream
    for (int i = 0; i < 10; i++) begin
      ops_d[i] = $urandom;
      ops_u[i] = 1'($urandom_range(0, 1));
      ops_r[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; prev_stall = 1'b0; prev_word = '0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 10) begin
        in_valid = 1'b1; in_data = ops_d[sent];
        in_unsigned = ops_u[sent]; in_rm = ops_r[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check("stall hold valid", out_valid, 1);
        check("stall hold data", {out_inexact, out_data}, prev_word);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("stream data", {out_inexact, out_data}, e);
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_inexact, out_data};
      if (in_valid && in_ready) begin
        exp_q.push_back(model({32'd0, in_data}, 32, in_unsigned, in_rm));
        sent++;
      end
    end
    check("stream results", got, 10);
    check("stream leftover", exp_q.size(), 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no duplicate", out_valid, 0);
    end

    // reset with three operations in flight behind a valid output
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'(k + 5); in_unsigned = 1'b0; in_rm = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset out_valid", out_valid, 1);
    rstn = 1'b0;
    #1;
    check("mid reset out_valid", out_valid, 0);
    check("mid reset out_data", out_data, 0);
    check("mid reset in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_vec(32'd3, 1'b0, 1'b0, 32'h40400000, 1'b0, "post-reset");

    // width sweep
    sweep(64'h0, 1'b0, 1'b0);
    sweep(64'h1, 1'b0, 1'b0);
    sweep('1, 1'b0, 1'b0);
    sweep('1, 1'b1, 1'b0);
    sweep('1, 1'b1, 1'b1);
    sweep(64'h80, 1'b0, 1'b0);
    check("w8 -128 hand", last8, 32'hC3000000);
    sweep(64'h7F, 1'b0, 1'b0);
    sweep(64'h8000, 1'b0, 1'b0);
    sweep(64'h7FFF, 1'b0, 1'b1);
    sweep(64'h8000_0000_0000_0000, 1'b0, 1'b0);
    check("w64 min hand", last64, 32'hDF000000);
    sweep(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    sweep(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      sweep({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/itof_pipe.md
# itof_pipe

Pipelined, parametrised integer-to-float converter for the FPU. It converts an `IN_W`-bit signed or unsigned integer to IEEE-754 single precision. Rounding is selectable per operation: round-to-nearest-even or round-toward-zero. The block has three register stages with a valid/ready handshake on both sides and sits between the integer register read port and the FPU writeback arbiter. It is the successor to the combinational single-cycle itof and adds width generality, an unsigned mode, selectable rounding, an inexact flag and backpressure.

## Interface
Parameters:
- `IN_W`, default 32: integer operand width, legal 8..64.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block accepts an operand this cycle.
- `in_data`  in  IN_W  integer operand.
- `in_unsigned`  in  1  1 = operand is unsigned, 0 = operand is two's complement.
- `in_rm`  in  1  rounding mode: 0 = RNE, 1 = RTZ.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  32  single-precision result.
- `out_inexact`  out  1  result differs from the exact value.

## Operation
- **S1 (sign/abs):**
  - sign = `in_data[IN_W-1]` when signed mode, else 0.
  - mag = two's-complement negate when sign = 1, else `in_data`; mag is IN_W bits and unsigned.
  - The most negative input negates to `2^(IN_W-1)` and is correct as unsigned.
- **S2 (normalise):**
  - `lzc` computes the leading-zero count z of mag.
  - e = IN_W-1-z.
  - norm = mag << z, so norm's MSB is the leading one.
  - zero flag = (mag == 0).
- **S3 (round/pack):**
  - frac = norm[IN_W-2 -: 23]; when IN_W-1 < 23, zero-pad on the right.
  - G = next bit below frac; S = OR of all remaining lower bits.
  - RNE increments frac when G & (S | frac[0]). RTZ never increments.
  - A carry out of frac (frac all ones) sets frac = 0 and e = e+1.
  - biased exponent = e+127, 8 bits; at most 191, so it never overflows.
  - inexact = G | S.
  - Zero input produces 0x00000000 with inexact 0, never -0.
- Per-operation mode bits (`in_unsigned`, `in_rm`) travel with the data through every stage.

## Timing
- **Latency:** 3 cycles. An operand accepted at edge N appears on `out_valid` after edge N+3 when there is no stall.
- **Throughput:** one operation per cycle.
- **Stall:** advance = !out_valid | out_ready.
  - All three stages load only when advance = 1.
  - `in_ready` = advance, combinationally.
  - When advance = 0, every stage register and `out_data` hold their values.
- **Bubbles:** each stage carries its own valid bit and bubbles propagate normally. Bubbles are not squeezed (global-stall pipeline).
- **Output stability:** `out_data` and `out_inexact` stay stable while out_valid & !out_ready.
- **Reset:** asserting `rstn` low, including mid-operation, immediately clears every stage valid. Reset values:
  - out_valid = 0
  - out_data = 0
  - out_inexact = 0
  - in_ready = 1 once the valids are clear
  
  In-flight operations are discarded. No data-path reset is needed beyond the valid bits and outputs.
- **Simultaneous events:** acceptance at the input and consumption at the output in the same cycle are both legal; both happen.

## Structure
- Package `itof_pkg`:
  - rounding-mode constants RM_RNE = 0 and RM_RTZ = 1
  - FP32 field widths (EXP_W = 8, FRAC_W = 23, BIAS = 127)
- Sub-module `lzc`: parametrised leading-zero counter (width parameter W; outputs count and all_zero), implemented as a combinational tree. It is reusable by the future ftoi/fadd normalisers.
- The top level holds the three pipeline register banks, the stall logic and the rounding/packing logic.

## Test plan
- **Exact conversions** (IN_W = 32, signed, RNE): 1 → 0x3F800000; -1 → 0xBF800000; 0 → 0x00000000. All have inexact 0.
- **Rounding** (RNE): 16777217 → 0x4B800000 (tie to even); 16777219 → 0x4B800002; 0x7FFFFFFF → 0x4F000000. All have inexact 1. Under RTZ, 0x7FFFFFFF → 0x4EFFFFFF.
- **Extremes:** signed 0x80000000 → 0xCF000000 with inexact 0. Unsigned 0xFFFFFFFF with RNE → 0x4F800000 (carry into exponent), inexact 1.
- **Backpressure:** stream 10 back-to-back random operands while out_ready toggles pseudo-randomly. Require:
  - in-order results that match the reference model
  - no loss and no duplication
  - out_data stable whenever valid & !ready
- **Reset mid-stream:** assert rstn with 3 operations in flight. Require out_valid = 0 immediately, and a new operand after reset appears exactly 3 cycles later.
- **Width sweep:** IN_W = 8, 16 and 64, random plus boundary values (0, ±1, min, max), checked against the model. For IN_W = 8, signed -128 → 0xC3000000.
